piso_tx_sched: RTL and testbench
================================

# piso_tx_sched

Round-robin transmit scheduler that shares one parallel-in/serial-out shift register among `NUM_REQ` requesters. Each requester offers a `DATA_W`-bit word on a valid/ready handshake. The scheduler grants one requester at a time, loads its word, and shifts it out MSB-first with framing strobes. It then inserts a programmable idle gap before the next grant. The block sits between the nibble producers and the single serial output pin.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `DATA_W`, default 4: word width shifted per frame, 2..16.
- `GAP_CYCLES`, default 1: idle cycles after the last bit of a frame, 0..15.

Ports:
- `clk`, input, 1: clock; all logic on rising edge.
- `rst`, input, 1: reset, synchronous, active-low.
- `req_valid`, input, `NUM_REQ`: per-requester word valid.
- `req_data`, input, `NUM_REQ*DATA_W`: requester i's word in bits `[i*DATA_W +: DATA_W]`.
- `req_ready`, output, `NUM_REQ`: one-hot accept; the word transfers on the edge where `req_valid[i] & req_ready[i]`.
- `sout`, output, 1: serial data; 0 when not shifting.
- `sout_valid`, output, 1: high on each cycle carrying a data bit.
- `frame_start`, output, 1: high on the first bit of a frame only.
- `grant_id`, output, `$clog2(NUM_REQ)`: index of the requester whose frame is on `sout`; holds its last value when idle.
- `busy`, output, 1: high in SHIFT and GAP.

## Operation
- FSM states: IDLE, SHIFT, GAP.
- IDLE:
  - `req_ready` is the combinational round-robin winner among asserted `req_valid`, gated by state==IDLE.
  - The search starts at `(last_grant+1) mod NUM_REQ`.
  - If any `req_valid` is set: at the edge, shift reg <= selected word, `grant_id` <= winner, `last_grant` <= winner, bit counter <= `DATA_W-1`, next state SHIFT.
  - If no `req_valid` is set: remain in IDLE, all `req_ready` = 0.
- SHIFT:
  - `sout` = shift reg MSB and `sout_valid` = 1.
  - Each edge: shift left with zero fill, decrement counter.
  - When counter==0: go to GAP if `GAP_CYCLES>0`, else go to IDLE.
- GAP: `sout` = 0 and `sout_valid` = 0. Count `GAP_CYCLES` cycles, then go to IDLE.
- `req_ready` is 0 in SHIFT and GAP. The word is captured at grant, so requester data changes after the handshake do not affect the frame.
- A requester may drop `req_valid` before it is granted. This is not an error, and it is excluded from arbitration that cycle.
- Round-robin guarantees that no continuously-valid requester waits more than `NUM_REQ-1` frames.

## Timing
- Reset values: state IDLE, `sout`=0, `sout_valid`=0, `frame_start`=0, `busy`=0, `req_ready`=0 during reset, `grant_id`=0, `last_grant`=`NUM_REQ-1` (requester 0 wins first).
- Handshake at edge T. Bits appear in cycles T+1..T+`DATA_W`, MSB first. `frame_start` is high in cycle T+1 only.
- Gap occupies cycles T+`DATA_W`+1..T+`DATA_W`+`GAP_CYCLES`. IDLE follows in the next cycle, where the next grant can occur.
- Frame period under continuous requests: `DATA_W`+`GAP_CYCLES`+1 cycles.
- Reset asserted mid-frame: at that edge all outputs return to reset values, the frame is aborted and not retransmitted, and `last_grant` resets.
- All outputs except `req_ready` are registered. `req_ready` is combinational from `req_valid` and state, with no combinational path to `req_data`.

## Structure
- Shared package `piso_sched_pkg`:
  - state enum (IDLE/SHIFT/GAP);
  - a round-robin select function (request vector, last grant) returning a one-hot grant and an index.
- Natural sub-module `piso_shifter`. Ports: `clk`, `rst`, `load`, `shift`, `din[DATA_W]`, `sout`. It provides load-priority, left shift with zero fill, and `sout` = MSB.
- The FSM, counters and arbiter stay in the top level.

## Test plan
- Reset then single request: `req_valid`=0001, word 4'b1011 → `req_ready[0]` high 1 cycle; `sout` = 1,0,1,1 over 4 cycles; `frame_start` on the first bit; `grant_id`=0.
- All four requesters valid with words A,B,C,D held → grants in order 0,1,2,3,0, each frame 6 cycles apart (`GAP_CYCLES`=1).
- Requester 2 changes `req_data` one cycle after its handshake → the transmitted bits equal the word captured at grant.
- `GAP_CYCLES`=0, requester 1 always valid → frames back-to-back with exactly one IDLE cycle between them (period 5).
- `rst` low on the 2nd bit of a frame → next cycle `sout`=0, `sout_valid`=0, `busy`=0; after release requester 0 has priority.
- `req_valid[3]` pulsed and withdrawn while another frame is shifting → no grant to requester 3, and no `req_ready[3]` outside IDLE.

Source files
------------

// File: rtl/piso_sched_pkg.sv
// Shared types and the round-robin selector for the PISO transmit scheduler.
package piso_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int MAX_REQ   = 8;
  localparam int MAX_REQ_W = 3;

  typedef struct packed {
    logic                 any;
    logic [MAX_REQ_W-1:0] idx;
    logic [MAX_REQ-1:0]   onehot;
  } rr_grant_t;

  // Search starts just after the last winner, so the last winner is tried last.
  function automatic rr_grant_t rr_select(input logic [MAX_REQ-1:0]   req,
                                          input logic [MAX_REQ_W-1:0] last,
                                          input int                   num_req);
    rr_grant_t g;
    int        cand;
    g    = '0;
    cand = 0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      if (k <= num_req && !g.any) begin
        cand = (int'(last) + k) % num_req;
        if (req[cand[MAX_REQ_W-1:0]]) begin
          g.any                            = 1'b1;
          g.idx                            = cand[MAX_REQ_W-1:0];
          g.onehot[cand[MAX_REQ_W-1:0]]    = 1'b1;
        end
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/piso_shifter.sv
// Parallel-in/serial-out shift register: load wins over shift, MSB goes out first.
module piso_shifter
  import piso_sched_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] din,
  output logic              sout
);

  logic [DATA_W-1:0] sreg;

  // Zero fill leaves the register empty after a frame, so sout idles at 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= din;
    end else if (shift) begin
      sreg <= {sreg[DATA_W-2:0], 1'b0};
    end
  end

  assign sout = sreg[DATA_W-1];

endmodule

// File: rtl/piso_tx_sched.sv
// Round-robin scheduler sharing one PISO shifter among NUM_REQ requesters,
// with framing strobes and a programmable idle gap between frames.
module piso_tx_sched
  import piso_sched_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       sout,
  output logic                       sout_valid,
  output logic                       frame_start,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
);

  localparam int GID_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [3:0] GAP_LOAD = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t               state;
  state_t               state_next;
  logic [GID_W-1:0]     last_grant;
  logic [CNT_W-1:0]     bit_cnt;
  logic [3:0]           gap_cnt;
  logic [MAX_REQ-1:0]   req_vec;
  logic [MAX_REQ_W-1:0] last_ext;
  rr_grant_t            rr;
  logic                 grant;
  logic                 shift_en;
  logic [GID_W-1:0]     win_idx;
  logic [DATA_W-1:0]    win_word;
  logic                 unused_rr;

  always_comb begin
    req_vec                  = '0;
    req_vec[NUM_REQ-1:0]     = req_valid;
    last_ext                 = '0;
    last_ext[GID_W-1:0]      = last_grant;
    rr                       = rr_select(req_vec, last_ext, NUM_REQ);
  end

  assign win_idx   = rr.idx[GID_W-1:0];
  assign win_word  = req_data[int'(win_idx)*DATA_W +: DATA_W];
  assign unused_rr = ^{rr.onehot, rr.idx};

  // Grants only happen in IDLE and never while reset is held, which keeps
  // req_ready low during reset even though it is combinational.
  always_comb begin
    state_next = state;
    grant      = 1'b0;
    shift_en   = 1'b0;
    case (state)
      IDLE: begin
        if (rst && rr.any) begin
          grant      = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (bit_cnt == '0) begin
          state_next = (GAP_CYCLES > 0) ? GAP : IDLE;
        end
      end
      GAP: begin
        if (gap_cnt == '0) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign req_ready = grant ? rr.onehot[NUM_REQ-1:0] : '0;

  // Status strobes are registered from the next state so they line up with sout.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      sout_valid  <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
      grant_id    <= '0;
      last_grant  <= GID_W'(NUM_REQ - 1);
      bit_cnt     <= '0;
      gap_cnt     <= '0;
    end else begin
      state       <= state_next;
      sout_valid  <= (state_next == SHIFT);
      frame_start <= grant;
      busy        <= (state_next != IDLE);
      if (grant) begin
        grant_id   <= win_idx;
        last_grant <= win_idx;
        bit_cnt    <= CNT_W'(DATA_W - 1);
      end else if (state == SHIFT) begin
        bit_cnt <= bit_cnt - 1'b1;
      end
      if (state == SHIFT && bit_cnt == '0) begin
        gap_cnt <= GAP_LOAD;
      end else if (state == GAP) begin
        gap_cnt <= gap_cnt - 1'b1;
      end
    end
  end

  piso_shifter #(
    .DATA_W (DATA_W)
  ) u_shifter (
    .clk   (clk),
    .rst   (rst),
    .load  (grant),
    .shift (shift_en),
    .din   (win_word),
    .sout  (sout)
  );

endmodule

// File: tb/tb_piso_tx_sched.sv
// Bench for piso_tx_sched: two instances (gap 1 and gap 0) share stimulus and
// are checked every cycle against a frame-timeline reference model.
module tb_piso_tx_sched;

  localparam int N = 4;
  localparam int W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   req_data;
  logic [1:0][N-1:0] rdy;
  logic [1:0]       so, sv, fs, bz;
  logic [1:0][1:0]  gid;

  int vectors     = 0;
  int miscompares = 0;

  piso_tx_sched #(.NUM_REQ(N), .DATA_W(W), .GAP_CYCLES(1)) dut_gap1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(rdy[0]), .sout(so[0]), .sout_valid(sv[0]),
    .frame_start(fs[0]), .grant_id(gid[0]), .busy(bz[0])
  );

  piso_tx_sched #(.NUM_REQ(N), .DATA_W(W), .GAP_CYCLES(0)) dut_gap0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(rdy[1]), .sout(so[1]), .sout_valid(sv[1]),
    .frame_start(fs[1]), .grant_id(gid[1]), .busy(bz[1])
  );

  always #5 clk = ~clk;

  // Reference model: each frame is a timeline starting the cycle after its grant.
  int         gaps[2] = '{1, 0};
  int         cyc = 0;
  bit         m_act[2];
  int         m_start[2], m_free[2], m_last[2], m_gid[2];
  logic [W-1:0] m_word[2];
  logic [1:0] e_so, e_sv, e_fs, e_bz;
  logic [1:0][1:0]   e_gid;
  logic [1:0][N-1:0] e_rdy;

  always @(negedge clk) begin : model
    int t, win;
    for (int d = 0; d < 2; d++) begin
      t        = cyc - m_start[d];
      e_sv[d]  = m_act[d] && t >= 0 && t < W;
      e_so[d]  = 1'b0;
      if (e_sv[d]) e_so[d] = m_word[d][W-1-t];
      e_fs[d]  = m_act[d] && t == 0;
      e_bz[d]  = m_act[d] && t >= 0 && t < W + gaps[d];
      e_gid[d] = 2'(m_gid[d]);
      win = -1;
      if (rst && cyc >= m_free[d]) begin
        for (int k = 1; k <= N; k++) begin
          if (win < 0 && req_valid[(m_last[d] + k) % N]) win = (m_last[d] + k) % N;
        end
      end
      e_rdy[d] = '0;
      if (win >= 0) e_rdy[d][win] = 1'b1;
      if (!rst) begin
        m_act[d]  = 1'b0;
        m_last[d] = N - 1;
        m_gid[d]  = 0;
        m_free[d] = cyc + 1;
      end else if (win >= 0) begin
        m_act[d]   = 1'b1;
        m_start[d] = cyc + 1;
        m_word[d]  = req_data[win*W +: W];
        m_gid[d]   = win;
        m_last[d]  = win;
        m_free[d]  = cyc + 1 + W + gaps[d];
      end
    end
    cyc++;
  end

  function automatic logic [9:0] obs(int d);
    return {rdy[d], so[d], sv[d], fs[d], bz[d], gid[d]};
  endfunction

  function automatic logic [9:0] expv(int d);
    return {e_rdy[d], e_so[d], e_sv[d], e_fs[d], e_bz[d], e_gid[d]};
  endfunction

  task automatic applyStimulus(input logic r, input logic [N-1:0] v, input logic [N*W-1:0] dat);
    @(posedge clk); #1;
    rst       = r;
    req_valid = v;
    req_data  = dat;
    @(negedge clk); #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (obs(d) !== expv(d)) begin
          miscompares++;
          $display("FAIL reset dut%0d t=%0t got=%h want=%h", d, $time, obs(d), expv(d));
        end
      end
    end
    vectors++;
    if (rdy[0] !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_ready got=%b want=0000", rdy[0]);
    end
  endtask

  task automatic test_single();
    logic [W-1:0]   got = '0;
    int             nbits = 0;
    int             first_gid = -1;
    logic [N*W-1:0] dat = N*W'($urandom);
    dat[W-1:0] = 4'b1011;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, (i == 0) ? 4'b0001 : 4'b0000, dat);
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (obs(d) !== expv(d)) begin
          miscompares++;
          $display("FAIL single dut%0d t=%0t got=%h want=%h", d, $time, obs(d), expv(d));
        end
      end
      if (i == 0) begin
        vectors++;
        if (rdy[0] !== 4'b0001) begin
          miscompares++;
          $display("FAIL single_ready got=%b want=0001", rdy[0]);
        end
      end
      if (sv[0]) begin
        got = {got[W-2:0], so[0]};
        nbits++;
      end
      if (fs[0] && first_gid < 0) first_gid = int'(gid[0]);
    end
    vectors++;
    if (got !== 4'b1011 || nbits != 4 || first_gid != 0) begin
      miscompares++;
      $display("FAIL single_frame got=%b/%0d bits/id%0d want=1011/4 bits/id0", got, nbits, first_gid);
    end
  endtask

  task automatic test_round_robin();
    int             ids[2][$];
    int             at[2][$];
    int             want_ids[5] = '{0, 1, 2, 3, 0};
    logic [N*W-1:0] dat = N*W'($urandom);
    applyStimulus(1'b0, '0, dat);
    for (int i = 0; i < 34; i++) begin
      applyStimulus(1'b1, 4'b1111, dat);
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (obs(d) !== expv(d)) begin
          miscompares++;
          $display("FAIL round_robin dut%0d t=%0t got=%h want=%h", d, $time, obs(d), expv(d));
        end
        if (fs[d]) begin
          ids[d].push_back(int'(gid[d]));
          at[d].push_back(i);
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if (ids[d].size() < 5) begin
        miscompares++;
        $display("FAIL rr_frames dut%0d got=%0d frames want>=5", d, ids[d].size());
      end else begin
        for (int k = 0; k < 5; k++) begin
          vectors++;
          if (ids[d][k] != want_ids[k]) begin
            miscompares++;
            $display("FAIL rr_order dut%0d frame%0d got=%0d want=%0d", d, k, ids[d][k], want_ids[k]);
          end
          if (k > 0 && at[d][k] - at[d][k-1] != W + 1 + gaps[d]) begin
            miscompares++;
            $display("FAIL rr_period dut%0d frame%0d got=%0d want=%0d", d, k,
                     at[d][k] - at[d][k-1], W + 1 + gaps[d]);
          end
        end
      end
    end
  endtask

  task automatic test_capture();
    logic [N*W-1:0] dat = N*W'($urandom);
    logic [W-1:0]   word = dat[2*W +: W];
    logic [W-1:0]   got = '0;
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, '0, dat);
    for (int i = 0; i < 10; i++) begin
      if (i >= 1) dat[2*W +: W] = ~word;
      applyStimulus(1'b1, (i == 0) ? 4'b0100 : 4'b0000, dat);
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (obs(d) !== expv(d)) begin
          miscompares++;
          $display("FAIL capture dut%0d t=%0t got=%h want=%h", d, $time, obs(d), expv(d));
        end
      end
      if (sv[0]) got = {got[W-2:0], so[0]};
    end
    vectors++;
    if (got !== word) begin
      miscompares++;
      $display("FAIL capture_word got=%b want=%b", got, word);
    end
  endtask

  task automatic test_gap0();
    int at[2][$];
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, '0, N*W'($urandom));
    for (int i = 0; i < 24; i++) begin
      applyStimulus(1'b1, 4'b0010, N*W'($urandom));
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (obs(d) !== expv(d)) begin
          miscompares++;
          $display("FAIL gap0 dut%0d t=%0t got=%h want=%h", d, $time, obs(d), expv(d));
        end
        if (fs[d]) at[d].push_back(i);
      end
    end
    vectors++;
    if (at[1].size() < 4) begin
      miscompares++;
      $display("FAIL gap0_frames got=%0d want>=4", at[1].size());
    end else begin
      for (int k = 1; k < at[1].size(); k++) begin
        vectors++;
        if (at[1][k] - at[1][k-1] != W + 1) begin
          miscompares++;
          $display("FAIL gap0_period got=%0d want=%0d", at[1][k] - at[1][k-1], W + 1);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int             first_gid = -1;
    logic [N*W-1:0] dat = N*W'($urandom);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, '0, dat);
    for (int i = 0; i < 12; i++) begin
      case (i)
        0:       applyStimulus(1'b1, 4'b0100, dat);
        1:       applyStimulus(1'b1, 4'b0000, dat);
        2:       applyStimulus(1'b0, 4'b0000, dat);
        default: applyStimulus(1'b1, (i < 5) ? 4'b1111 : 4'b0000, dat);
      endcase
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (obs(d) !== expv(d)) begin
          miscompares++;
          $display("FAIL reset_mid dut%0d t=%0t got=%h want=%h", d, $time, obs(d), expv(d));
        end
      end
      if (i == 3) begin
        vectors++;
        if ({so[0], sv[0], bz[0]} !== 3'b000) begin
          miscompares++;
          $display("FAIL reset_mid_abort got=%b want=000", {so[0], sv[0], bz[0]});
        end
      end
      if (i > 3 && fs[0] && first_gid < 0) first_gid = int'(gid[0]);
    end
    vectors++;
    if (first_gid != 0) begin
      miscompares++;
      $display("FAIL reset_mid_prio got=%0d want=0", first_gid);
    end
  endtask

  task automatic test_withdraw();
    int             rdy3 = 0;
    int             gid3 = 0;
    logic [N*W-1:0] dat = N*W'($urandom);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, '0, dat);
    for (int i = 0; i < 14; i++) begin
      applyStimulus(1'b1, (i == 0) ? 4'b0001 : (i < 3) ? 4'b1000 : 4'b0000, dat);
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (obs(d) !== expv(d)) begin
          miscompares++;
          $display("FAIL withdraw dut%0d t=%0t got=%h want=%h", d, $time, obs(d), expv(d));
        end
        if (rdy[d][3]) rdy3++;
        if (fs[d] && gid[d] == 2'd3) gid3++;
      end
    end
    vectors++;
    if (rdy3 != 0 || gid3 != 0) begin
      miscompares++;
      $display("FAIL withdraw_req3 got ready=%0d frames=%0d want 0/0", rdy3, gid3);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 59) != 0), N'($urandom), N*W'($urandom));
      for (int d = 0; d < 2; d++) begin
        vectors++;
        if (obs(d) !== expv(d)) begin
          miscompares++;
          $display("FAIL random dut%0d t=%0t got=%h want=%h", d, $time, obs(d), expv(d));
        end
      end
    end
  endtask

  initial begin
    rst       = 1'b0;
    req_valid = 4'b1111;
    req_data  = N*W'($urandom);
    test_reset();
    applyStimulus(1'b1, '0, req_data);
    test_single();
    test_round_robin();
    test_capture();
    test_gap0();
    test_reset_mid();
    test_withdraw();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
